// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin time-sliced access to a shared 16:1 one-bit mux.
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset
//   i_req      per-channel level request
//   i_i        mux data inputs, one bit per channel
//   i_en       arbitration enable; low blocks new grants and ends the current one
//   o_s        mux select (index of current or last grantee)
//   o_gnt      one-hot grant
//   o_busy     high while a grant is held
//   o_x        registered I[S] sampled during grant
//   o_x_valid  o_x was sampled in the previous cycle under grant
module mux_rr_scheduler #(
    parameter int N       = 16,
    parameter int SW      = 4,
    parameter int QUANTUM = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_i,
    input  logic          i_en,
    output logic [SW-1:0] o_s,
    output logic [N-1:0]  o_gnt,
    output logic          o_busy,
    output logic          o_x,
    output logic          o_x_valid
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        r_state;
    logic [SW-1:0] r_ptr;
    logic [3:0]    r_cnt;
    logic [SW-1:0] w_win;
    logic [SW-1:0] w_idx;
    logic          w_release;
    // Scan from the farthest offset down so the nearest requester at or after r_ptr wins;
    // the SW-bit add wraps modulo N because N == 2**SW.
    always_comb begin
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = r_ptr + SW'(k);
            w_win = i_req[w_idx] ? w_idx : w_win;
        end
    end
    assign w_release = !i_req[o_s] || r_cnt == 4'(QUANTUM) || !i_en;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            o_s       <= '0;
            o_gnt     <= '0;
            o_busy    <= 1'b0;
            o_x       <= 1'b0;
            o_x_valid <= 1'b0;
        end else if (r_state == IDLE) begin
            o_x_valid <= 1'b0;
            if (i_en && |i_req) begin
                o_s     <= w_win;
                o_gnt   <= N'(1) << w_win;
                o_busy  <= 1'b1;
                r_cnt   <= 4'd1;
                r_state <= GRANT;
            end
        end else begin
            o_x       <= i_i[o_s];
            o_x_valid <= 1'b1;
            if (w_release) begin
                o_gnt   <= '0;
                o_busy  <= 1'b0;
                r_ptr   <= o_s + SW'(1);
                r_cnt   <= '0;
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_scheduler.sv
// tb_mux_rr_scheduler: directed and random stimulus against a behavioural scheduler model.
module tb_mux_rr_scheduler;
    localparam int N = 16;
    localparam int Q = 4;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  din = '0;
    logic          en  = 1'b0;
    logic [3:0]    s;
    logic [N-1:0]  gnt;
    logic          busy, x, x_valid;
    int n_vec = 0;
    int n_err = 0;
    int owner = -1;
    int last_sel = 0;
    int held = 0;
    int first = 0;
    int m_x = 0;
    int m_xv = 0;
    always #5 clk = ~clk;
    mux_rr_scheduler #(.N(N), .SW(4), .QUANTUM(Q)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_i(din), .i_en(en),
        .o_s(s), .o_gnt(gnt), .o_busy(busy), .o_x(x), .o_x_valid(x_valid)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    // Apply one cycle of inputs, advance the model by the rules of the scheduler, compare after the edge.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] d, input logic e);
        rst = r; req = rq; din = d; en = e;
        if (r) begin
            owner = -1; last_sel = 0; held = 0; first = 0; m_x = 0; m_xv = 0;
        end else if (owner < 0) begin
            m_xv = 0;
            if (e && rq != 0) begin
                for (int k = 0; k < N; k++)
                    if (owner < 0 && rq[(first + k) % N]) owner = (first + k) % N;
                last_sel = owner;
                held = 1;
            end
        end else begin
            m_x = int'(d[owner]);
            m_xv = 1;
            if (!rq[owner] || held == Q || !e) begin
                first = (owner + 1) % N;
                owner = -1;
                held = 0;
            end else begin
                held++;
            end
        end
        @(posedge clk);
        #1;
        check("gnt", 32'(gnt), owner < 0 ? 32'h0 : 32'h1 << owner);
        check("s", 32'(s), 32'(last_sel));
        check("busy", 32'(busy), 32'(owner >= 0));
        check("x", 32'(x), 32'(m_x));
        check("x_valid", 32'(x_valid), 32'(m_xv));
    endtask
    initial begin
        logic [N-1:0] rq;
        repeat (2) step(1, '0, '0, 0);
        for (int c = 0; c < 12; c++) step(0, 16'h0001, '0, 1);
        step(1, '0, '0, 0);
        for (int c = 0; c < 14; c++) step(0, 16'h8001, 16'h8000, 1);
        step(1, '0, '0, 0);
        for (int c = 0; c < 85; c++) step(0, 16'hFFFF, 16'hAAAA, 1);
        step(1, '0, '0, 0);
        step(0, 16'h0020, 16'h0020, 1);
        step(0, 16'h0020, 16'h0020, 1);
        step(0, 16'h0020, 16'h0020, 1);
        for (int c = 0; c < 6; c++) step(0, 16'h0410, 16'h0400, 1);
        step(1, '0, '0, 0);
        step(0, 16'h0008, 16'h0008, 1);
        step(0, 16'h0008, 16'h0008, 1);
        for (int c = 0; c < 5; c++) step(0, 16'hFFFF, 16'hFFFF, 0);
        step(1, '0, '0, 0);
        step(0, 16'h0200, 16'h0200, 1);
        step(0, 16'h0200, 16'h0200, 1);
        step(1, 16'h0200, 16'h0200, 1);
        for (int c = 0; c < 6; c++) step(0, 16'h0202, 16'h0002, 1);
        for (int c = 0; c < 1500; c++) begin
            rq = N'($urandom) & N'($urandom) & N'($urandom);
            if ($urandom_range(0, 7) == 0) rq = '0;
            step($urandom_range(0, 99) == 0, rq, N'($urandom), $urandom_range(0, 9) != 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
